// File: rtl/axis_frame_packer.sv
// Packs fixed-length frames from CH_NUM producer channels onto one AXI-Stream output.
// A round-robin arbiter locks one channel per frame; beats pass through one output register.
module axis_frame_packer #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned FRAME_BEATS = 400,
    parameter int unsigned INTR_WIDTH  = 4,
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned USER_WIDTH = $clog2(CH_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CH_NUM-1:0]            ch_vld,
    input  logic [CH_NUM*DATA_WIDTH-1:0] ch_data,
    output logic [CH_NUM-1:0]            ch_rdy,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic [USER_WIDTH-1:0]        m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         frame_intr,
    output logic [31:0]                  frame_cnt
);

    localparam logic [15:0] LastBeat = 16'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e                  state_q, state_d;
    logic [USER_WIDTH-1:0]   grant_q, grant_d;
    logic [USER_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [15:0]             beat_cnt_q, beat_cnt_d;
    logic [31:0]             frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [USER_WIDTH-1:0]   tuser_q;
    logic                    tlast_q;
    logic                    tvalid_q;
    logic                    intr_q;
    logic [3:0]              intr_cnt_q;
    logic [USER_WIDTH-1:0]   rr_idx;
    logic [USER_WIDTH-1:0]   rr_pick;
    logic                    rr_hit;
    logic                    accept;
    logic                    frame_done;
    logic [DATA_WIDTH-1:0]   ch_beat [CH_NUM];

    for (genvar g = 0; g < CH_NUM; g++) begin : g_split
        assign ch_beat[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        rr_idx  = '0;
        rr_pick = last_grant_q;
        rr_hit  = 1'b0;
        for (int i = int'(CH_NUM); i >= 1; i--) begin
            rr_idx = USER_WIDTH'((int'(last_grant_q) + i) % int'(CH_NUM));
            if (ch_vld[rr_idx]) begin
                rr_pick = rr_idx;
                rr_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        ch_rdy       = '0;
        accept       = 1'b0;
        frame_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && rr_hit) begin
                    grant_d    = rr_pick;
                    beat_cnt_d = '0;
                    state_d    = StStream;
                end
            end
            StStream: begin
                ch_rdy[grant_q] = !tvalid_q || m_axis_tready;
                accept          = ch_vld[grant_q] && ch_rdy[grant_q];
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == LastBeat) begin
                        state_d      = StFlush;
                        last_grant_d = grant_q;
                    end
                end
            end
            StFlush: begin
                if (tvalid_q && m_axis_tready && tlast_q) begin
                    frame_done  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= USER_WIDTH'(CH_NUM - 1);
            beat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Output stage: reload on accept, otherwise hold until the sink takes the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (accept) begin
            tdata_q  <= ch_beat[grant_q];
            tuser_q  <= grant_q;
            tlast_q  <= (beat_cnt_q == LastBeat);
            tvalid_q <= 1'b1;
        end else if (m_axis_tready) begin
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end
    end

    // A new completion reloads the count, so overlapping pulses merge and stretch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_q     <= 1'b0;
            intr_cnt_q <= '0;
        end else if (frame_done) begin
            intr_q     <= 1'b1;
            intr_cnt_q <= 4'(INTR_WIDTH - 1);
        end else if (intr_cnt_q != 4'd0) begin
            intr_cnt_q <= intr_cnt_q - 4'd1;
        end else begin
            intr_q     <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = {KEEP_WIDTH{tvalid_q}};
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_intr    = intr_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: scoreboarded beats plus a table of per-frame arbitration cases
// and hand-written sequences for enable drop, mid-frame reset and frame counter wrap.
module tb_axis_frame_packer;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FB = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CH-1:0]    ch_vld;
    logic [CH*DW-1:0] ch_data;
    logic [CH-1:0]    ch_rdy;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic [UW-1:0]    m_axis_tuser;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             frame_intr;
    logic [31:0]      frame_cnt;

    axis_frame_packer #(
        .CH_NUM      (CH),
        .DATA_WIDTH  (DW),
        .FRAME_BEATS (FB),
        .INTR_WIDTH  (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .ch_vld        (ch_vld),
        .ch_data       (ch_data),
        .ch_rdy        (ch_rdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_intr    (frame_intr),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        logic [CH-1:0] mask;
        logic [3:0]    rdy_pat;
        logic [UW-1:0] exp_user;
        logic [31:0]   exp_cnt;
    } vec_t;

    beat_t         sb[$];
    vec_t          vecs [9];
    int            n_chk = 0;
    int            n_fail = 0;
    int unsigned   ch_seq [CH];
    int unsigned   seq_ofs;
    logic [3:0]    rdy_pat;
    logic [1:0]    phase = 2'd0;
    logic [CH-1:0] acc_mask;
    int            acc_idx;
    int            pops = 0;
    int            pop_idx;
    int            cyc = 0;
    int            start_cyc;
    int            span;
    logic [UW-1:0] last_user;
    logic [31:0]   frame_bytes;
    logic          hold_pend;
    beat_t         hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Producer data: channel tag in the top byte, per-channel sequence in the low byte.
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < int'(CH); i++)
            ch_data[i*DW +: DW] = {8'hC0 + 8'(i), 16'h0000, 8'(ch_seq[i] + seq_ofs)};
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(CH); i++)
            if (acc_mask[i]) ch_seq[i] = ch_seq[i] + 1;
        m_axis_tready = rdy_pat[phase];
        phase = phase + 2'd1;
    end

    always @(negedge clk) begin
        beat_t exp_b;
        beat_t nb;
        cyc++;
        if (rst) begin
            sb.delete();
            acc_idx   = 0;
            acc_mask  = '0;
            hold_pend = 1'b0;
            pop_idx   = 0;
        end else begin
            check("rdy_onehot", ($countones(ch_rdy) <= 1) ? 32'd1 : 32'd0, 32'd1);
            check("tkeep", 32'(m_axis_tkeep), m_axis_tvalid ? 32'hF : 32'h0);
            if (hold_pend) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", m_axis_tdata, hold.data);
                check("hold_user", 32'(m_axis_tuser), 32'(hold.user));
                check("hold_last", 32'(m_axis_tlast), 32'(hold.last));
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold      = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_beat: got unexpected beat 0x%0h, expected none", m_axis_tdata);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat_data", m_axis_tdata, exp_b.data);
                    check("beat_user", 32'(m_axis_tuser), 32'(exp_b.user));
                    check("beat_last", 32'(m_axis_tlast), 32'(exp_b.last));
                end
                pops++;
                frame_bytes = {frame_bytes[23:0], m_axis_tdata[7:0]};
                if (pop_idx == 0) start_cyc = cyc;
                if (m_axis_tlast) begin
                    last_user = m_axis_tuser;
                    span      = cyc - start_cyc;
                    pop_idx   = 0;
                end else begin
                    pop_idx++;
                end
            end
            acc_mask = ch_vld & ch_rdy;
            for (int i = 0; i < int'(CH); i++) begin
                if (acc_mask[i]) begin
                    nb.data = ch_data[i*DW +: DW];
                    nb.user = UW'(i);
                    nb.last = (acc_idx == int'(FB) - 1);
                    sb.push_back(nb);
                    acc_idx = (acc_idx == int'(FB) - 1) ? 0 : acc_idx + 1;
                end
            end
        end
    end

    task automatic wait_cnt_change(input logic [31:0] c0);
        for (int k = 0; k < 400 && frame_cnt == c0; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pops(input int target);
        for (int k = 0; k < 200 && pops < target; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [CH-1:0] mask, input logic [3:0] pat,
                             input logic [UW-1:0] exp_user, input logic [31:0] exp_cnt);
        logic [31:0] c0;
        int n;
        c0      = frame_cnt;
        rdy_pat = pat;
        ch_vld  = mask;
        en      = 1'b1;
        wait_cnt_change(c0);
        ch_vld = '0;
        check("frame_cnt", frame_cnt, exp_cnt);
        check("frame_user", 32'(last_user), 32'(exp_user));
        n = 0;
        while (frame_intr && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("intr_len", n, IW);
        if (pat == 4'hF) check("frame_span", span, FB - 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] c0;
        int p0;
        logic quiet;
        rst     = 1'b1;
        en      = 1'b0;
        ch_vld  = '0;
        rdy_pat = 4'hF;
        seq_ofs = 0;
        // Arbitration walk from reset (last grant = 3); each row is one complete frame.
        vecs[0] = '{4'b0001, 4'hF,    2'd0, 32'd1};
        vecs[1] = '{4'b1010, 4'hF,    2'd1, 32'd2};
        vecs[2] = '{4'b1010, 4'hF,    2'd3, 32'd3};
        vecs[3] = '{4'b1010, 4'hF,    2'd1, 32'd4};
        vecs[4] = '{4'b1010, 4'hF,    2'd3, 32'd5};
        vecs[5] = '{4'b1111, 4'b1001, 2'd0, 32'd6};
        vecs[6] = '{4'b0110, 4'hF,    2'd1, 32'd7};
        vecs[7] = '{4'b1100, 4'hF,    2'd2, 32'd8};
        vecs[8] = '{4'b0011, 4'b0101, 2'd0, 32'd9};

        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tkeep", 32'(m_axis_tkeep), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_intr", 32'(frame_intr), 32'd0);
        check("rst_cnt", frame_cnt, 32'd0);
        check("rst_rdy", 32'(ch_rdy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++)
            run_frame(vecs[v].mask, vecs[v].rdy_pat, vecs[v].exp_user, vecs[v].exp_cnt);

        // Stalled sink: beats A1..A4 must come out intact while tready goes 1,0,0,1.
        seq_ofs = 32'hA1 - ch_seq[0];
        run_frame(4'b0001, 4'b1001, 2'd0, 32'd10);
        check("stall_bytes", frame_bytes, 32'hA1A2A3A4);

        // Enable dropped after the second beat: frame finishes, then nothing new starts.
        c0 = frame_cnt;
        p0 = pops;
        rdy_pat = 4'hF;
        ch_vld  = 4'b0100;
        en      = 1'b1;
        wait_pops(p0 + 2);
        en = 1'b0;
        wait_cnt_change(c0);
        check("en_low_cnt", frame_cnt, 32'd11);
        check("en_low_user", 32'(last_user), 32'd2);
        p0 = pops;
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid || ch_rdy != '0) quiet = 1'b0;
        end
        check("en_low_idle", 32'(quiet), 32'd1);
        check("en_low_pops", pops, p0);
        run_frame(4'b0100, 4'hF, 2'd2, 32'd12);

        // Mid-frame reset on channel 3: partial frame dropped, arbiter restarts at channel 0.
        p0 = pops;
        ch_vld = 4'b1000;
        en     = 1'b1;
        wait_pops(p0 + 2);
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("mid_rst_cnt", frame_cnt, 32'd0);
        check("mid_rst_rdy", 32'(ch_rdy), 32'd0);
        check("mid_rst_intr", 32'(frame_intr), 32'd0);
        ch_vld = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(4'b1001, 4'hF, 2'd0, 32'd1);

        // Counter wrap from a preloaded value.
        force dut.frame_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        run_frame(4'b0001, 4'hF, 2'd0, 32'hFFFF_FFFF);
        run_frame(4'b0010, 4'hF, 2'd1, 32'h0000_0000);

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
